// File: rtl/writeback_queue_pkg.sv
// Shared types and constants for the register-file writeback queue.
// Entries carry a destination register and the result to be written there.
package writeback_queue_pkg;

  localparam int WB_DEPTH   = 4;
  localparam int WB_CNT_W   = 3;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // x0 is hardwired, so writes to it are dropped and never tracked
  function automatic logic is_real_rd(input logic [REG_ADDR_W-1:0] rd);
    return rd != {REG_ADDR_W{1'b0}};
  endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Producer, decode and register-file signals of the writeback queue.
// The slave side is the queue itself; master is whoever drives the producers.
interface writeback_queue_if;
  import writeback_queue_pkg::*;

  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  mem_ready;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  alu_ready;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_ready;
  logic [REG_ADDR_W-1:0] query_rs1;
  logic [REG_ADDR_W-1:0] query_rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] reg_in_addr;
  logic [XLEN-1:0]       reg_data_in;

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
           issue_valid, issue_rd, query_rs1, query_rs2,
    input  mem_ready, alu_ready, issue_ready, rs1_busy, rs2_busy,
           reg_write, reg_in_addr, reg_data_in
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
           issue_valid, issue_rd, query_rs1, query_rs2,
    output mem_ready, alu_ready, issue_ready, rs1_busy, rs2_busy,
           reg_write, reg_in_addr, reg_data_in
  );

endinterface

// File: rtl/writeback_fifo.sv
// Two-push / one-pop circular buffer with occupancy count.
// When both pushes fire, push0 lands ahead of push1; the caller prevents overflow.
module writeback_fifo
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push0_valid,
  input  wb_entry_t              push0_entry,
  input  logic                   push1_valid,
  input  wb_entry_t              push1_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  wb_entry_t        buf_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_next_s;
  logic [OCC_W-1:0] occ_r;
  logic [OCC_W-1:0] push_cnt_s;

  // Second write slot and number of entries entering this cycle
  always_comb begin
    wr_ptr_next_s = wr_ptr_r + PTR_W'(1'b1);
    push_cnt_s    = OCC_W'(push0_valid) + OCC_W'(push1_valid);
  end

  // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is 2^n
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= '0;
      end
    end else begin
      if (push0_valid) begin
        buf_r[wr_ptr_r] <= push0_entry;
      end
      if (push1_valid) begin
        buf_r[push0_valid ? wr_ptr_next_s : wr_ptr_r] <= push1_entry;
      end
      wr_ptr_r <= wr_ptr_r + push_cnt_s[PTR_W-1:0];
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop);
      occ_r    <= occ_r + push_cnt_s - OCC_W'(pop);
    end
  end

  assign head = buf_r[rd_ptr_r];
  assign occ  = occ_r;

endmodule

// File: rtl/writeback_queue.sv
// Writeback front end: merges ALU and load results into an in-order queue,
// drains one per cycle to the register file and tracks pending writes per register.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int CNT_W = WB_CNT_W
) (
  input logic              clk,
  input logic              reset,
  writeback_queue_if.slave bus
);

  localparam int               OCC_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [OCC_W:0]   LAST_SLOT = (OCC_W + 1)'(DEPTH - 1);

  logic [OCC_W-1:0]    occ_s;
  wb_entry_t           head_s;
  wb_entry_t           mem_entry_s;
  wb_entry_t           alu_entry_s;
  logic                mem_ready_s;
  logic                alu_ready_s;
  logic                mem_push_s;
  logic                alu_push_s;
  logic                pop_s;
  logic                issue_ready_s;
  logic [NUM_REGS-1:0] inc_s;
  logic [NUM_REGS-1:0] dec_s;
  logic [CNT_W-1:0]    cnt_r [NUM_REGS];

  // Readiness looks only at current occupancy; a same-cycle pop is not credited
  always_comb begin
    mem_ready_s = ({1'b0, occ_s} <= LAST_SLOT);
    alu_ready_s = (({1'b0, occ_s} + {{OCC_W{1'b0}}, bus.mem_valid}) <= LAST_SLOT);
    mem_push_s  = bus.mem_valid && mem_ready_s && is_real_rd(bus.mem_rd);
    alu_push_s  = bus.alu_valid && alu_ready_s && is_real_rd(bus.alu_rd);
    mem_entry_s = '{rd: bus.mem_rd, data: bus.mem_data};
    alu_entry_s = '{rd: bus.alu_rd, data: bus.alu_data};
    pop_s       = (occ_s != '0);
  end

  writeback_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0_valid(mem_push_s),
    .push0_entry(mem_entry_s),
    .push1_valid(alu_push_s),
    .push1_entry(alu_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .occ        (occ_s)
  );

  // Per-register increment (issue) and decrement (retire) strobes
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    issue_ready_s = !(is_real_rd(bus.issue_rd) && (cnt_r[bus.issue_rd] == CNT_MAX));
    inc_s[bus.issue_rd] = bus.issue_valid && issue_ready_s && is_real_rd(bus.issue_rd);
    dec_s[head_s.rd]    = pop_s;
  end

  // Pending counters; x0 is never touched, retiring at zero saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc_s[i] && !dec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1'b1);
        end else if (dec_s[i] && !inc_s[i] && (cnt_r[i] != '0)) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1'b1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Register-file port driven straight from the queue head
  always_comb begin
    bus.mem_ready   = mem_ready_s;
    bus.alu_ready   = alu_ready_s;
    bus.issue_ready = issue_ready_s;
    bus.reg_write   = pop_s;
    bus.reg_in_addr = '0;
    bus.reg_data_in = '0;
    if (pop_s) begin
      bus.reg_in_addr = head_s.rd;
      bus.reg_data_in = head_s.data;
    end else begin
      bus.reg_in_addr = '0;
      bus.reg_data_in = '0;
    end
    bus.rs1_busy = is_real_rd(bus.query_rs1) && (cnt_r[bus.query_rs1] != '0);
    bus.rs2_busy = is_real_rd(bus.query_rs2) && (cnt_r[bus.query_rs2] != '0);
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a per-cycle vector table plus hand-written
// sequences for filling, counter saturation and reset while busy.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  writeback_queue_if bus ();

  writeback_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mv; logic [4:0] mrd; logic [31:0] mdata;
    logic av; logic [4:0] ard; logic [31:0] adata;
    logic iv; logic [4:0] ird; logic [4:0] q1; logic [4:0] q2;
    logic mr; logic ar; logic ir; logic wr; logic [4:0] wa; logic [31:0] wd;
    logic b1; logic b2;
  } vec_t;

  vec_t      vecs [11];
  wb_entry_t model_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                       input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] q1, input logic [4:0] q2);
    @(negedge clk);
    bus.mem_valid   = mv;
    bus.mem_rd      = mrd;
    bus.mem_data    = mdata;
    bus.alu_valid   = av;
    bus.alu_rd      = ard;
    bus.alu_data    = adata;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    bus.query_rs1   = q1;
    bus.query_rs2   = q2;
    #1;
  endtask

  task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, q1, q2);
  endtask

  task automatic chk_wr(input string name, input logic wr, input logic [4:0] wa,
                        input logic [31:0] wd);
    chk({name, "_reg_write"}, 32'(bus.reg_write), 32'(wr));
    chk({name, "_addr"}, 32'(bus.reg_in_addr), 32'(wa));
    chk({name, "_data"}, bus.reg_data_in, wd);
  endtask

  task automatic chk_outs(input string name, input logic mr, input logic ar, input logic ir,
                          input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                          input logic b1, input logic b2);
    chk({name, "_mem_ready"}, 32'(bus.mem_ready), 32'(mr));
    chk({name, "_alu_ready"}, 32'(bus.alu_ready), 32'(ar));
    chk({name, "_issue_ready"}, 32'(bus.issue_ready), 32'(ir));
    chk_wr(name, wr, wa, wd);
    chk({name, "_rs1_busy"}, 32'(bus.rs1_busy), 32'(b1));
    chk({name, "_rs2_busy"}, 32'(bus.rs2_busy), 32'(b2));
  endtask

  initial begin
    // mv mrd mdata | av ard adata | iv ird q1 q2 || mr ar ir wr wa wd b1 b2
    vecs[0]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd5, 5'd7,
                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd5, 5'd0,
                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 5'd5, 5'd0,
                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd5, 5'd0,
                 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd5, 5'd0,
                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};
    vecs[5]  = '{1'b1, 5'd3, 32'hAAAA_0000, 1'b1, 5'd3, 32'h5555_0000, 1'b1, 5'd3, 5'd3, 5'd5,
                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd3, 5'd3,
                 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'hAAAA_0000, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd3, 5'd0,
                 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h5555_0000, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd3, 5'd0,
                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'h0BAD_F00D, 1'b1, 5'd0, 5'd0, 5'd0,
                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd0,
                 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0};

    reset = 1'b1;
    bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.query_rs1 = 5'd1; bus.query_rs2 = 5'd2;
    #1;
    chk_outs("in_reset", 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Table: single write latency, mem-before-alu ordering, x0 writes
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].mv, vecs[i].mrd, vecs[i].mdata, vecs[i].av, vecs[i].ard, vecs[i].adata,
            vecs[i].iv, vecs[i].ird, vecs[i].q1, vecs[i].q2);
      chk_outs($sformatf("vec%0d", i), vecs[i].mr, vecs[i].ar, vecs[i].ir, vecs[i].wr,
               vecs[i].wa, vecs[i].wd, vecs[i].b1, vecs[i].b2);
    end

    // Both producers every cycle from empty; no pending counts so retirements hit zero
    for (int k = 0; k < 6; k++) begin
      logic [4:0]  mrd;
      logic [4:0]  ard;
      logic [31:0] md;
      logic [31:0] ad;
      logic        exp_mr;
      logic        exp_ar;
      int          occ;
      mrd = 5'(1 + k);
      ard = 5'(16 + k);
      md  = 32'hA000_0000 + 32'(k);
      ad  = 32'hB000_0000 + 32'(k);
      drive(1'b1, mrd, md, 1'b1, ard, ad, 1'b0, 5'd0, 5'd1, 5'd16);
      occ    = model_q.size();
      exp_mr = (occ <= 3);
      exp_ar = (occ + 1 <= 3);
      chk($sformatf("fill%0d_mem_ready", k), 32'(bus.mem_ready), 32'(exp_mr));
      chk($sformatf("fill%0d_alu_ready", k), 32'(bus.alu_ready), 32'(exp_ar));
      if (occ != 0) begin
        chk_wr($sformatf("fill%0d", k), 1'b1, model_q[0].rd, model_q[0].data);
        void'(model_q.pop_front());
      end else begin
        chk_wr($sformatf("fill%0d", k), 1'b0, 5'd0, 32'h0);
      end
      if (exp_mr) model_q.push_back('{rd: mrd, data: md});
      if (exp_ar) model_q.push_back('{rd: ard, data: ad});
    end
    for (int c = 0; c < 10 && model_q.size() != 0; c++) begin
      idle(5'd1, 5'd16);
      chk_wr($sformatf("drain%0d", c), 1'b1, model_q[0].rd, model_q[0].data);
      void'(model_q.pop_front());
    end
    idle(5'd1, 5'd16);
    chk_outs("drained", 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // x7: three issues, retire one at a time; busy holds until the last
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
      chk($sformatf("x7_issue%0d_ready", i), 32'(bus.issue_ready), 32'd1);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("x7_a_busy", 32'(bus.rs1_busy), 32'd1);
    chk_wr("x7_a", 1'b0, 5'd0, 32'h0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h71, 1'b0, 5'd0, 5'd7, 5'd0);
    chk_wr("x7_b", 1'b1, 5'd7, 32'h70);
    idle(5'd7, 5'd0);
    chk_wr("x7_c", 1'b1, 5'd7, 32'h71);
    chk("x7_c_busy", 32'(bus.rs1_busy), 32'd1);
    idle(5'd7, 5'd0);
    chk("x7_one_left_busy", 32'(bus.rs1_busy), 32'd1);
    chk_wr("x7_d", 1'b0, 5'd0, 32'h0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h72, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("x7_e_busy", 32'(bus.rs1_busy), 32'd1);
    idle(5'd7, 5'd0);
    chk_wr("x7_f", 1'b1, 5'd7, 32'h72);
    chk("x7_f_busy", 32'(bus.rs1_busy), 32'd1);
    idle(5'd7, 5'd0);
    chk("x7_cleared_busy", 32'(bus.rs1_busy), 32'd0);

    // Saturate x7 at 7 pending, then free one slot by retiring
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
      chk($sformatf("sat_issue%0d_ready", i), 32'(bus.issue_ready), 32'd1);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    chk("sat_full_ready", 32'(bus.issue_ready), 32'd0);
    chk("sat_full_busy", 32'(bus.rs1_busy), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd8, 5'd0);
    chk("sat_other_ready", 32'(bus.issue_ready), 32'd1);
    chk("sat_other_busy", 32'(bus.rs1_busy), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h73, 1'b0, 5'd7, 5'd7, 5'd0);
    chk("sat_still_full", 32'(bus.issue_ready), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7, 5'd0);
    chk_wr("sat_retire", 1'b1, 5'd7, 32'h73);
    chk("sat_retire_ready", 32'(bus.issue_ready), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7, 5'd0);
    chk("sat_freed_ready", 32'(bus.issue_ready), 32'd1);

    // Reset with three entries queued, x9 and x7 pending
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    drive(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h110, 1'b0, 5'd0, 5'd9, 5'd0);
    chk("rst_pre_busy9", 32'(bus.rs1_busy), 32'd1);
    drive(1'b1, 5'd12, 32'h120, 1'b1, 5'd13, 32'h130, 1'b0, 5'd0, 5'd9, 5'd0);
    chk_wr("rst_pre_a", 1'b1, 5'd10, 32'h100);
    idle(5'd9, 5'd7);
    chk_wr("rst_pre_b", 1'b1, 5'd11, 32'h110);
    chk("rst_pre_busy7", 32'(bus.rs2_busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk_outs("rst_async", 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      idle(5'd9, 5'd13);
      chk_outs($sformatf("post_rst%0d", c), 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
